// File: rtl/decoder_pkg.sv
// Shared definitions for the token decoder (and its encoder counterpart):
// FSM state encoding, stream markers, default widths and the status flags.
package decoder_pkg;

    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_DATA_WIDTH = 8;

    // Vocab entry terminator and end-of-token-stream marker at default width.
    localparam logic [DEF_DATA_WIDTH-1:0] DELIM   = '0;
    localparam logic [DEF_DATA_WIDTH-1:0] TOK_END = '1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_SEEK  = 3'd2,
        S_COPY  = 3'd3,
        S_TERM  = 3'd4,
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_e;

    // Registered status outputs, always updated together with the state.
    typedef struct packed {
        logic busy;
        logic done;
        logic error;
    } status_t;

    localparam status_t ST_IDLE = '{busy: 1'b0, done: 1'b0, error: 1'b0};
    localparam status_t ST_BUSY = '{busy: 1'b1, done: 1'b0, error: 1'b0};
    localparam status_t ST_DONE = '{busy: 1'b0, done: 1'b1, error: 1'b0};
    localparam status_t ST_ERR  = '{busy: 1'b0, done: 1'b0, error: 1'b1};

endpackage

// File: rtl/decoder_entry_locator.sv
// Locates the start of vocab entry <skip_id> by counting delimiters while
// the FSM streams vocab addresses. Reports the entry start once the skip
// count is exhausted, or a fault when the search runs off the vocab end.
module entry_locator
    import decoder_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,        // new token accepted: restart search
    input  logic [DATA_WIDTH-1:0] skip_id_i,     // number of entries to skip
    input  logic                  active_i,      // FSM is in SEEK
    input  logic [ADDR_WIDTH-1:0] voc_addr_i,    // vocab address presented this cycle
    input  logic [DATA_WIDTH-1:0] voc_data_i,    // data for last cycle's address
    output logic                  found_o,
    output logic [ADDR_WIDTH-1:0] entry_start_o,
    output logic                  fault_o
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
    localparam logic [DATA_WIDTH-1:0] DELIM_W  = DATA_WIDTH'(DELIM);

    logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] start_q, start_d;
    logic                  rd_valid_q, rd_valid_d;  // voc_data_i belongs to rd_addr_q
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;

    // Track which address the returning data belongs to and count delimiters.
    always_comb begin
        cnt_d      = cnt_q;
        start_d    = start_q;
        rd_valid_d = rd_valid_q;
        rd_addr_d  = rd_addr_q;
        if (load_i) begin
            cnt_d      = skip_id_i;
            start_d    = '0;
            rd_valid_d = 1'b0;
        end else if (active_i) begin
            rd_valid_d = 1'b1;
            rd_addr_d  = voc_addr_i;
            // A delimiter at the last address cannot open a new entry;
            // that case is reported through fault_o instead.
            if (rd_valid_q && (cnt_q != '0) && (voc_data_i == DELIM_W) &&
                (rd_addr_q != ADDR_MAX)) begin
                cnt_d   = cnt_q - 1'b1;
                start_d = rd_addr_q + 1'b1;
            end
        end
    end

    // Search state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            start_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_addr_q  <= '0;
        end else begin
            cnt_q      <= cnt_d;
            start_q    <= start_d;
            rd_valid_q <= rd_valid_d;
            rd_addr_q  <= rd_addr_d;
        end
    end

    // Still skipping while the last vocab word is being examined means the
    // wanted entry would start beyond the vocab memory.
    assign found_o       = active_i && (cnt_q == '0);
    assign fault_o       = active_i && rd_valid_q && (cnt_q != '0) && (rd_addr_q == ADDR_MAX);
    assign entry_start_o = start_q;

endmodule

// File: rtl/decoder.sv
// Token decoder: reads token ids, finds each id's string in a delimiter-
// packed vocab memory and streams the characters into an output memory,
// closing the output with a delimiter.
//
// Interface protocol: cs is a level enable (no handshake); all memories are
// synchronous-read, data returns the cycle after the address; out_we writes
// out_data to out_addr on each high cycle. All outputs are registered.
module decoder
    import decoder_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs,
    output logic [ADDR_WIDTH-1:0] tok_addr,
    input  logic [DATA_WIDTH-1:0] tok_data,
    output logic [ADDR_WIDTH-1:0] voc_addr,
    input  logic [DATA_WIDTH-1:0] voc_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_we,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [2:0]            dbg_state
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = '1;
    localparam logic [DATA_WIDTH-1:0] DELIM_W   = DATA_WIDTH'(DELIM);
    localparam logic [DATA_WIDTH-1:0] TOK_END_W = {DATA_WIDTH{TOK_END[0]}};

    state_e                state_q;
    status_t               status_q;
    logic [ADDR_WIDTH-1:0] tok_addr_q;
    logic [ADDR_WIDTH-1:0] voc_addr_q;
    logic [ADDR_WIDTH-1:0] out_addr_q;     // address of the write on out_we
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_we_q;
    logic [ADDR_WIDTH-1:0] wr_ptr_q;       // next free output address
    logic                  out_full_q;     // last output address holds data
    logic                  fetch_wait_q;   // token read issued, data next cycle
    logic                  copy_vld_q;     // voc_data is valid in COPY
    logic                  copy_at_end_q;  // voc_data came from the last vocab word

    logic                  loc_load;
    logic                  loc_found;
    logic                  loc_fault;
    logic [ADDR_WIDTH-1:0] loc_start;
    logic [ADDR_WIDTH-1:0] voc_next;

    // Vocab reads stream one address per cycle but never wrap; running off
    // the end is caught when the last word's data comes back.
    assign voc_next = (voc_addr_q == ADDR_MAX) ? voc_addr_q : voc_addr_q + 1'b1;

    assign loc_load = (state_q == S_FETCH) && cs && fetch_wait_q && (tok_data != TOK_END_W);

    entry_locator #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_locator (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_i        (loc_load),
        .skip_id_i     (tok_data),
        .active_i      (state_q == S_SEEK),
        .voc_addr_i    (voc_addr_q),
        .voc_data_i    (voc_data),
        .found_o       (loc_found),
        .entry_start_o (loc_start),
        .fault_o       (loc_fault)
    );

    // Decode FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            status_q      <= ST_IDLE;
            tok_addr_q    <= '0;
            voc_addr_q    <= '0;
            out_addr_q    <= '0;
            out_data_q    <= '0;
            out_we_q      <= 1'b0;
            wr_ptr_q      <= '0;
            out_full_q    <= 1'b0;
            fetch_wait_q  <= 1'b0;
            copy_vld_q    <= 1'b0;
            copy_at_end_q <= 1'b0;
        end else begin
            out_we_q <= 1'b0;  // strobe lasts exactly one cycle
            case (state_q)
                S_IDLE: begin
                    if (cs) begin
                        state_q      <= S_FETCH;
                        status_q     <= ST_BUSY;
                        tok_addr_q   <= '0;
                        out_addr_q   <= '0;
                        wr_ptr_q     <= '0;
                        out_full_q   <= 1'b0;
                        fetch_wait_q <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (!cs) begin
                        state_q  <= S_IDLE;
                        status_q <= ST_IDLE;
                    end else if (!fetch_wait_q) begin
                        fetch_wait_q <= 1'b1;
                    end else if (tok_data == TOK_END_W) begin
                        // The terminator write is issued here so its strobe
                        // lands in TERM.
                        if (out_full_q) begin
                            state_q  <= S_ERROR;
                            status_q <= ST_ERR;
                        end else begin
                            state_q    <= S_TERM;
                            out_we_q   <= 1'b1;
                            out_addr_q <= wr_ptr_q;
                            out_data_q <= DELIM_W;
                        end
                    end else begin
                        state_q    <= S_SEEK;
                        voc_addr_q <= '0;
                    end
                end
                S_SEEK: begin
                    if (!cs) begin
                        state_q  <= S_IDLE;
                        status_q <= ST_IDLE;
                    end else if (loc_fault) begin
                        state_q  <= S_ERROR;
                        status_q <= ST_ERR;
                    end else if (loc_found) begin
                        state_q    <= S_COPY;
                        voc_addr_q <= loc_start;
                        copy_vld_q <= 1'b0;
                    end else begin
                        voc_addr_q <= voc_next;
                    end
                end
                S_COPY: begin
                    if (!cs) begin
                        state_q  <= S_IDLE;
                        status_q <= ST_IDLE;
                    end else begin
                        voc_addr_q    <= voc_next;
                        copy_vld_q    <= 1'b1;
                        copy_at_end_q <= (voc_addr_q == ADDR_MAX);
                        if (copy_vld_q) begin
                            if (voc_data == DELIM_W) begin
                                // Entry complete; the token stream may not run
                                // past the last token address.
                                if (tok_addr_q == ADDR_MAX) begin
                                    state_q  <= S_ERROR;
                                    status_q <= ST_ERR;
                                end else begin
                                    state_q      <= S_FETCH;
                                    tok_addr_q   <= tok_addr_q + 1'b1;
                                    fetch_wait_q <= 1'b0;
                                end
                            end else if (copy_at_end_q || out_full_q) begin
                                // Entry unterminated inside the vocab, or no
                                // room left: abort without writing.
                                state_q  <= S_ERROR;
                                status_q <= ST_ERR;
                            end else begin
                                out_we_q   <= 1'b1;
                                out_addr_q <= wr_ptr_q;
                                out_data_q <= voc_data;
                                if (wr_ptr_q == ADDR_MAX) begin
                                    out_full_q <= 1'b1;
                                end else begin
                                    wr_ptr_q <= wr_ptr_q + 1'b1;
                                end
                            end
                        end
                    end
                end
                S_TERM: begin
                    if (!cs) begin
                        state_q  <= S_IDLE;
                        status_q <= ST_IDLE;
                    end else begin
                        state_q  <= S_DONE;
                        status_q <= ST_DONE;
                    end
                end
                S_DONE, S_ERROR: begin
                    // Held until cs drops, so a steady cs cannot restart.
                    if (!cs) begin
                        state_q  <= S_IDLE;
                        status_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    status_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tok_addr  = tok_addr_q;
    assign voc_addr  = voc_addr_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;
    assign out_we    = out_we_q;
    assign busy      = status_q.busy;
    assign done      = status_q.done;
    assign error     = status_q.error;
    assign dbg_state = state_q;

endmodule

// File: doc/decoder.md
DECODER -- requirements
Module: decoder

Interface
REQ-001 Parameter ADDR_WIDTH, default 4: address width of token, vocab and output memories.
REQ-002 Parameter DATA_WIDTH, default 8: width of token ids and characters.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cs  input  1  level start/enable; decode runs while high.
REQ-006 tok_addr  output  ADDR_WIDTH  token-memory read address.
REQ-007 tok_data  input  DATA_WIDTH  token-memory read data, valid one cycle after tok_addr.
REQ-008 voc_addr  output  ADDR_WIDTH  vocab-memory read address.
REQ-009 voc_data  input  DATA_WIDTH  vocab-memory read data, valid one cycle after voc_addr.
REQ-010 out_addr  output  ADDR_WIDTH  output-memory write address.
REQ-011 out_data  output  DATA_WIDTH  output-memory write data.
REQ-012 out_we  output  1  output-memory write strobe, one write per high cycle.
REQ-013 busy  output  1  high in any state other than IDLE, DONE, ERROR.
REQ-014 done  output  1  decode finished without error.
REQ-015 error  output  1  decode aborted on a boundary fault.

Function
REQ-016 Vocab format: entry n is the (n+1)-th string of characters terminated by DELIM (0x00), packed from vocab address 0.
REQ-017 Token format: ids from token address 0, stream terminated by TOK_END (all ones).
REQ-018 States: IDLE, FETCH, SEEK, COPY, TERM, DONE, ERROR.
REQ-019 IDLE -> FETCH on cs high; tok_addr, out_addr cleared to 0.
REQ-020 FETCH: issue tok_addr, capture tok_data next cycle; TOK_END -> TERM; else load skip counter = id, voc_addr = 0 -> SEEK.
REQ-021 SEEK: read vocab sequentially, decrement skip counter on each DELIM; at zero -> COPY with voc_addr at entry start.
REQ-022 COPY: each non-DELIM voc_data written to out_addr with out_we high, out_addr incremented; DELIM -> tok_addr+1, FETCH.
REQ-023 Throughput: one character written per cycle in steady-state COPY after one-cycle read latency.
REQ-024 TERM: write DELIM at out_addr (one out_we cycle) -> DONE.
REQ-025 DONE: done high, held until cs low, then IDLE.
REQ-026 ERROR: error high, held until cs low, then IDLE.
REQ-027 voc_addr wraps at 2^ADDR_WIDTH-1 in SEEK or COPY -> ERROR (id outside vocab).
REQ-028 tok_addr passes 2^ADDR_WIDTH-1 without TOK_END -> ERROR.
REQ-029 Character or TERM write needed with out_addr already at 2^ADDR_WIDTH-1 holding data -> ERROR, no wrap, no overwrite.
REQ-030 Empty entry (DELIM at entry start): no write, next token fetched.
REQ-031 cs low in any busy state -> IDLE next cycle, out_we low that cycle, no further writes.
REQ-032 cs high with DONE/ERROR: no restart until cs has been low at least one cycle.
REQ-033 done and error never high together; out_we never high outside COPY/TERM.

Reset
REQ-034 rst_n low asynchronously forces IDLE; all addresses, out_data, out_we, busy, done, error to 0.
REQ-035 Reset mid-decode discards progress; written output memory is not cleared.

Structure
REQ-036 Package decoder_pkg holds state enum, DELIM, TOK_END and default widths, shared with encoder.
REQ-037 Sub-module entry_locator implements SEEK (skip counter, DELIM detect, vocab wrap detect) and reports entry start/fault.
REQ-038 Memories external; bench provides synchronous-read models.

Verification
REQ-039 Vocab "ab\0c\0xyz\0", tokens {2,0,1,TOK_END}, cs=1 -> output "xyzabc\0", done=1, error=0.
REQ-040 Tokens {TOK_END} -> single write of 0x00 at out_addr 0, done within 4 cycles.
REQ-041 Vocab of 3 entries, token id 5 -> error=1, done=0, no out_we after fault.
REQ-042 Entry longer than output space (16 chars into 16-entry memory) -> error at out_addr 15, nothing written past 15.
REQ-043 cs dropped mid-COPY of "xyz" after 'x' -> IDLE next cycle, only 'x' written; cs re-raise restarts from token 0.
REQ-044 rst_n pulsed low mid-SEEK -> all outputs 0 immediately, busy=0, IDLE.
